// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: words enter a small FIFO over valid/ready and are
// shifted out one bit per clock, back-to-back words chaining with no idle gap.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(WIDTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [0:0]       state_q, state_d;

  logic push, pop, full, at_last, out_bit;

  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign at_last  = (bit_cnt_q == LAST_CNT);

  always_comb begin
    pop       = 1'b0;
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      default: begin
        if (at_last) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end
        end else begin
          if (MSB_FIRST != 0) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          else                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
    endcase
    // A pop always reloads the shifter, whether from IDLE or chained at the last bit.
    if (pop) begin
      sreg_d    = mem[rd_ptr_q];
      bit_cnt_d = '0;
      state_d   = S_SHIFT;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      state_q   <= S_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      state_q   <= state_d;
    end
  end

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign out_bit = sreg_q[WIDTH-1];
    end else begin : g_lsb
      assign out_bit = sreg_q[0];
    end
  endgenerate

  assign x        = (state_q == S_SHIFT) ? out_bit : IDLE_BIT;
  assign x_valid  = (state_q == S_SHIFT);
  assign last_bit = (state_q == S_SHIFT) && at_last;
  assign busy     = (state_q == S_SHIFT) || (count_q != '0);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first instance with IDLE_BIT=0
// and an LSB-first instance with IDLE_BIT=1.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data_l;
  logic       in_valid, in_valid_l;
  logic       in_ready, x, x_valid, last_bit, busy;
  logic       in_ready_l, x_l, x_valid_l, last_bit_l, busy_l;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .x_valid(x_valid), .last_bit(last_bit), .busy(busy)
  );

  serial_bit_feeder #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b1)) u_dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .x(x_l), .x_valid(x_valid_l), .last_bit(last_bit_l), .busy(busy_l)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_valid_l = 1'b0; in_data_l = 8'h00;
    tick; tick;
    vectors++; if (x !== 1'b0) begin miscompares++; $display("FAIL rst_x got %b want 0", x); end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL rst_x_valid got %b want 0", x_valid); end
    vectors++; if (last_bit !== 1'b0) begin miscompares++; $display("FAIL rst_last_bit got %b want 0", last_bit); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vectors++; if (x_l !== 1'b1) begin miscompares++; $display("FAIL rst_x_idle1 got %b want 1", x_l); end
    #3 rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL rel_x_valid got %b want 0", x_valid); end
    tick;
  endtask

  task automatic test_single_word;
    logic [7:0] pat;
    pat = 8'hA8;
    in_data = pat; in_valid = 1'b1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sw_in_ready got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL sw_latency_x_valid got %b want 0", x_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL sw_busy_queued got %b want 1", busy); end
    tick;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (x !== pat[7-i]) begin miscompares++; $display("FAIL sw_x bit%0d got %b want %b", i, x, pat[7-i]); end
      vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL sw_x_valid bit%0d got %b want 1", i, x_valid); end
      vectors++; if (last_bit !== (i == 7)) begin miscompares++; $display("FAIL sw_last_bit bit%0d got %b want %b", i, last_bit, (i == 7)); end
      tick;
    end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL idle_drain_x_valid got %b want 0", x_valid); end
    vectors++; if (x !== 1'b0) begin miscompares++; $display("FAIL idle_drain_x got %b want 0", x); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_drain_busy got %b want 0", busy); end
    vectors++; if (last_bit !== 1'b0) begin miscompares++; $display("FAIL idle_drain_last_bit got %b want 0", last_bit); end
    $display("single_word: 8'hA8 shifted");
  endtask

  task automatic test_back_to_back;
    logic [15:0] pat;
    pat = {8'hAA, 8'h55};
    in_data = 8'hAA; in_valid = 1'b1;
    tick;
    in_data = 8'h55;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vectors++; if (x !== pat[15-i]) begin miscompares++; $display("FAIL b2b_x bit%0d got %b want %b", i, x, pat[15-i]); end
      vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_x_valid bit%0d got %b want 1", i, x_valid); end
      vectors++; if (last_bit !== (i == 7 || i == 15)) begin miscompares++; $display("FAIL b2b_last_bit bit%0d got %b want %b", i, last_bit, (i == 7 || i == 15)); end
      tick;
    end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain_x_valid got %b want 0", x_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drain_busy got %b want 0", busy); end
    $display("back_to_back: 8'hAA,8'h55 shifted");
  endtask

  task automatic test_fifo_full;
    logic [7:0] shw, exp_out;
    logic       acc, exp_rdy, done;
    int         n_in, n_out;
    shw = 8'h00; exp_out = 8'h00; n_in = 0; n_out = 0; done = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    tick;
    #3 rst = 1'b0;
    #1;
    for (int c = 1; c <= 300; c++) begin
      if (c == 61) in_valid = 1'b0;
      if (c <= 60) begin
        exp_rdy = (c <= 5) || (c >= 11 && ((c - 11) % 8) == 0);
        vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL fifo_in_ready edge%0d got %b want %b", c, in_ready, exp_rdy); end
      end
      if (x_valid === 1'b1) begin
        shw = {shw[6:0], x};
        if (last_bit === 1'b1) begin
          vectors++; if (shw !== exp_out) begin miscompares++; $display("FAIL fifo_order word%0d got %h want %h", n_out, shw, exp_out); end
          exp_out = exp_out + 8'd1;
          n_out++;
        end
      end
      acc = in_valid && in_ready;
      if (c > 60 && busy === 1'b0) begin done = 1'b1; break; end
      tick;
      if (acc) begin in_data = in_data + 8'd1; n_in++; end
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL fifo_drain_timeout got %b want 1", done); end
    vectors++; if (n_in != 12) begin miscompares++; $display("FAIL fifo_accepted got %0d want 12", n_in); end
    vectors++; if (n_out != 12) begin miscompares++; $display("FAIL fifo_emitted got %0d want 12", n_out); end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL fifo_final_x_valid got %b want 0", x_valid); end
    $display("fifo_full: %0d words in, %0d words out", n_in, n_out);
  endtask

  task automatic test_lsb_first;
    logic [7:0] pat;
    pat = 8'h15;
    in_data_l = pat; in_valid_l = 1'b1;
    vectors++; if (x_l !== 1'b1) begin miscompares++; $display("FAIL lsb_idle_x got %b want 1", x_l); end
    vectors++; if (in_ready_l !== 1'b1) begin miscompares++; $display("FAIL lsb_in_ready got %b want 1", in_ready_l); end
    tick;
    in_valid_l = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (x_l !== pat[i]) begin miscompares++; $display("FAIL lsb_x bit%0d got %b want %b", i, x_l, pat[i]); end
      vectors++; if (x_valid_l !== 1'b1) begin miscompares++; $display("FAIL lsb_x_valid bit%0d got %b want 1", i, x_valid_l); end
      vectors++; if (last_bit_l !== (i == 7)) begin miscompares++; $display("FAIL lsb_last_bit bit%0d got %b want %b", i, last_bit_l, (i == 7)); end
      tick;
    end
    vectors++; if (x_l !== 1'b1) begin miscompares++; $display("FAIL lsb_drain_x got %b want 1", x_l); end
    vectors++; if (x_valid_l !== 1'b0) begin miscompares++; $display("FAIL lsb_drain_x_valid got %b want 0", x_valid_l); end
    vectors++; if (busy_l !== 1'b0) begin miscompares++; $display("FAIL lsb_drain_busy got %b want 0", busy_l); end
    $display("lsb_first: 8'h15 shifted");
  endtask

  task automatic test_reset_mid_word;
    in_data = 8'hFF; in_valid = 1'b1;
    tick;
    in_data = 8'h0F;
    tick;
    in_valid = 1'b0;
    tick; tick; tick;
    vectors++; if (x !== 1'b1) begin miscompares++; $display("FAIL mid_bit3_x got %b want 1", x); end
    vectors++; if (x_valid !== 1'b1) begin miscompares++; $display("FAIL mid_bit3_x_valid got %b want 1", x_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (x !== 1'b0) begin miscompares++; $display("FAIL mid_rst_x got %b want 0", x); end
    vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_x_valid got %b want 0", x_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_in_ready got %b want 0", in_ready); end
    vectors++; if (last_bit !== 1'b0) begin miscompares++; $display("FAIL mid_rst_last_bit got %b want 0", last_bit); end
    tick;
    #3 rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rel_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 20; i++) begin
      tick;
      vectors++; if (x_valid !== 1'b0) begin miscompares++; $display("FAIL mid_discard_x_valid cyc%0d got %b want 0", i, x_valid); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_discard_busy cyc%0d got %b want 0", i, busy); end
    end
    $display("reset_mid_word: buffered words discarded");
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_fifo_full;
    test_lsb_first;
    test_reset_mid_word;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream feeder for the serial pattern detector. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Shifts each word out one bit per clock on `x`, with `x_valid` marking live bits. Back-to-back words stream with no idle gap, so a detector sampling `x` every clock sees patterns that span word boundaries.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `DEPTH`, 4: FIFO entries; power of 2, ≥ 2.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- `IDLE_BIT`, 0: value driven on `x` when no word is being shifted.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  parallel word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word this cycle.
- `x`  out  1  serial bit stream, to the detector's `x`.
- `x_valid`  out  1  `x` carries a word bit this cycle.
- `last_bit`  out  1  `x` carries the final bit of the current word.
- `busy`  out  1  FIFO non-empty or shifter active.

## Operation
- **Push:** a word is written at a rising edge with `in_valid && in_ready`. `in_ready = !full && !rst`. There is no bypass: a pushed word always passes through the FIFO.
- **Shifter FSM** has two states:
  - IDLE: when the FIFO is non-empty, pop the head, load it into the shift register, set `bit_cnt=0`, go to SHIFT.
  - SHIFT: each edge, shift one position toward the output end and increment `bit_cnt`.
    - At `bit_cnt==WIDTH-1` with the FIFO non-empty: pop, reload, `bit_cnt=0`, stay in SHIFT (zero-gap chaining).
    - At `bit_cnt==WIDTH-1` with the FIFO empty: go to IDLE.
- **Outputs:**
  - `x`: in SHIFT, `sreg[WIDTH-1]` when MSB_FIRST, else `sreg[0]`; in IDLE, `IDLE_BIT`.
  - `x_valid = (state==SHIFT)`.
  - `last_bit = (state==SHIFT && bit_cnt==WIDTH-1)`.
  - `busy = (state==SHIFT) || (count != 0)`.
  - `x`, `x_valid`, `last_bit` and `busy` are decoded from flops only; no combinational path from any input.
- **FIFO:**
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy `count` runs 0..DEPTH.
  - A simultaneous push and pop leaves `count` unchanged; both pointers advance.
  - Push when full cannot occur, because `in_ready=0`.
- **Reset (async, any time, including mid-word):**
  - Pointers, `count`, `bit_cnt` and shift register cleared; state IDLE.
  - `x=IDLE_BIT`, `x_valid=0`, `last_bit=0`, `busy=0`, `in_ready=0` while `rst` is high.
  - A partially shifted word and all buffered words are discarded.
  - `in_ready=1` in the first cycle after release.

## Timing
- **Latency:** word pushed at edge N with the shifter in IDLE → loaded at edge N+1 → first bit on `x` (with `x_valid=1`) in the cycle after edge N+1.
- Each word occupies exactly WIDTH consecutive `x_valid` cycles.
- Chained words produce no gap cycle between the last bit of one word and the first bit of the next.
- **Throughput:** sustained 1 word per WIDTH cycles. Input bursts beyond that rate are absorbed by the FIFO plus the shifter.
- **Steady burst:** with `in_valid` held high from reset release, exactly DEPTH+1 words are accepted on consecutive edges (one is loaded into the shifter after the first edge). `in_ready` then deasserts until the next pop.
- `in_ready` rises in the cycle after the pop edge that frees a slot.

## Test plan
- **Single word, MSB-first:** push 8'hA8 once.
  - `x` = 1,0,1,0,1,0,0,0 over 8 cycles starting 2 cycles after the push edge.
  - `x_valid` high for exactly those 8 cycles; `last_bit` only on the 8th.
  - The downstream detector asserts `z` once.
- **Back-to-back:** push 8'hAA then 8'h55 on consecutive edges.
  - 16 contiguous `x_valid` cycles: 10101010 01010101.
  - No gap cycle; `last_bit` pulses on bits 8 and 16.
- **FIFO full:** hold `in_valid=1` with `in_data` incrementing from 8'h00.
  - 5 words (00..04) accepted on consecutive edges, then `in_ready=0`.
  - Thereafter 1 word accepted per 8 cycles.
  - Output order is 00,01,02,… with no loss or duplication.
- **LSB-first:** set `MSB_FIRST=0`, push 8'h15.
  - `x` = 1,0,1,0,1,0,0,0.
- **Reset mid-word:** push 8'hFF and 8'h0F, then assert `rst` asynchronously during bit 3 of the first word.
  - `x=IDLE_BIT` and `x_valid=0` immediately; `busy=0`.
  - After release, no bits of either word appear.
  - `in_ready=1` in the first cycle after release.
- **Idle drain:** after the last word completes with the FIFO empty:
  - State returns to IDLE; `x=IDLE_BIT`, `x_valid=0`.
  - `busy` falls in the cycle after the final bit.
